uart_rx: RTL

//  Simple UART receiver: 8 data bits, no parity, 1+ stop bits, LSB first.

---
 rtl/uart_rx_pkg.sv | 34 +++
 rtl/uart_rx_sync_2ff.sv | 26 ++
 rtl/uart_rx.sv | 130 +++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: status word layout, FSM encoding
// and the default bit-time divider.
package uart_rx_pkg;

    localparam int RX_DATA_LSB          = 0;
    localparam int RX_FULL_BIT          = 8;
    localparam int RX_FERR_BIT          = 9;
    localparam int RX_OVR_BIT           = 10;
    localparam int DEFAULT_BAUD_DIVIDER = 434;
    localparam int TIMER_W              = 20;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    function automatic logic [31:0] rx_status_word(
        input logic [7:0] data,
        input logic       full,
        input logic       ferr,
        input logic       ovr
    );
        logic [31:0] word;
        word                       = 32'd0;
        word[RX_DATA_LSB +: 8]     = data;
        word[RX_FULL_BIT]          = full;
        word[RX_FERR_BIT]          = ferr;
        word[RX_OVR_BIT]           = ovr;
        return word;
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-stage synchroniser for an asynchronous input; resets to 1 so an idle-high
// line never produces a spurious edge out of reset.
module sync_2ff (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two flops in series to settle metastability before the value is used.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1, LSB first) with a single-byte holding register and
// full / framing-error / overrun status on a simple valid/ready bus.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUD_DIVIDER = DEFAULT_BAUD_DIVIDER
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_instr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_rdata,
    input  logic        serialIn
);

    localparam logic [TIMER_W-1:0] TIMER_MAX  = TIMER_W'(BAUD_DIVIDER);
    localparam logic [TIMER_W-1:0] TIMER_HALF = TIMER_W'(BAUD_DIVIDER / 2);

    logic               rx_s;
    logic               rx_prev_q;
    logic               rx_fall_s;
    logic               timer_wrap_s;
    logic               read_accept_s;
    logic               unused_bus_s;
    rx_state_e          state_q;
    logic [TIMER_W-1:0] bit_timer_q;
    logic [3:0]         bit_count_q;
    logic [7:0]         shifter_q;
    logic [7:0]         data_q;
    logic               rx_full_q;
    logic               frame_err_q;
    logic               overrun_q;
    logic               rdy_q;
    logic [31:0]        rdata_q;

    sync_2ff u_sync (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     (serialIn),
        .q_o     (rx_s)
    );

    assign rx_fall_s     = rx_prev_q & ~rx_s;
    assign timer_wrap_s  = (bit_timer_q == TIMER_MAX);
    assign read_accept_s = mem_valid & enable & ~rdy_q & (mem_wstrb == 4'b0000);
    assign unused_bus_s  = ^{mem_instr, mem_wdata, mem_addr};

    // Receive FSM, bit timer, holding register and bus handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RX_IDLE;
            rx_prev_q   <= 1'b1;
            bit_timer_q <= '0;
            bit_count_q <= 4'd0;
            shifter_q   <= 8'd0;
            data_q      <= 8'd0;
            rx_full_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            rdy_q       <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            rx_prev_q   <= rx_s;
            bit_timer_q <= timer_wrap_s ? '0 : bit_timer_q + TIMER_W'(1);
            rdy_q       <= mem_valid & enable & ~rdy_q;

            if (read_accept_s) begin
                rdata_q     <= rx_status_word(data_q, rx_full_q, frame_err_q, overrun_q);
                rx_full_q   <= 1'b0;
                frame_err_q <= 1'b0;
                overrun_q   <= 1'b0;
            end

            case (state_q)
                RX_IDLE: begin
                    if (rx_fall_s) begin
                        bit_timer_q <= TIMER_HALF;
                        state_q     <= RX_START;
                    end
                end
                RX_START: begin
                    if (timer_wrap_s) begin
                        if (!rx_s) begin
                            bit_count_q <= 4'd8;
                            state_q     <= RX_DATA;
                        end else begin
                            state_q <= RX_IDLE;
                        end
                    end
                end
                RX_DATA: begin
                    if (timer_wrap_s) begin
                        shifter_q   <= {rx_s, shifter_q[7:1]};
                        bit_count_q <= bit_count_q - 4'd1;
                        if (bit_count_q == 4'd1) begin
                            state_q <= RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    // A read in this same cycle consumes the old byte, so delivery wins.
                    if (timer_wrap_s) begin
                        state_q <= RX_IDLE;
                        if (!rx_full_q || read_accept_s) begin
                            data_q    <= shifter_q;
                            rx_full_q <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                        if (!rx_s) begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= RX_IDLE;
                end
            endcase
        end
    end

    assign mem_ready = enable ? rdy_q : 1'b0;
    assign mem_rdata = enable ? rdata_q : 32'd0;

endmodule
